// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I(+M) decoder sitting between fetch
// and execute. Adds strict illegal-instruction detection, load-use stalls and a
// 2-entry skid buffer so that in_ready never depends on out_ready.

package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } alu_srca_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_srcb_t;

  // Store data width, taken from the STORE funct3
  typedef enum logic [1:0] {
    WD_BYTE = 2'd0,
    WD_HALF = 2'd1,
    WD_WORD = 2'd2
  } mem_wdsrc_t;

  typedef enum logic [1:0] {
    DOUT_ALUY = 2'd0,
    DOUT_MEM  = 2'd1,
    DOUT_PC4  = 2'd2
  } dataout_src_t;

  typedef enum logic [2:0] {
    IMMG_NONE = 3'd0,
    IMMG_I    = 3'd1,
    IMMG_S    = 3'd2,
    IMMG_B    = 3'd3,
    IMMG_U    = 3'd4,
    IMMG_J    = 3'd5
  } immg_op_t;

  typedef enum logic [3:0] {
    BJ_NOOP = 4'd0,
    BJ_BEQ  = 4'd1,
    BJ_BNE  = 4'd2,
    BJ_BLT  = 4'd3,
    BJ_BGE  = 4'd4,
    BJ_BLTU = 4'd5,
    BJ_BGEU = 4'd6,
    BJ_JAL  = 4'd7,
    BJ_JALR = 4'd8
  } bj_op_t;

  // Every "inactive" encoding is zero, so an all-zero bundle is a safe bubble
  typedef struct packed {
    alu_op_t      alu_op;
    alu_srca_t    alu_srca;
    alu_srcb_t    alu_srcb;
    mem_wdsrc_t   mem_d_wdsrc;
    logic         mem_d_we;
    dataout_src_t dataout_src;
    logic         reg_we;
    immg_op_t     immg_op;
    bj_op_t       bj_op;
  } controlsgs_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              ex_load_valid,
  input  logic [4:0]        ex_load_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output controlsgs_t       out_controlsgs,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic              out_muldiv,
  output logic [2:0]        out_mdop
);

  // One decoded instruction as held in the main or skid register
  typedef struct packed {
    controlsgs_t      ctrl;
    logic [XLEN-1:0]  pc;
    logic [31:0]      instr;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             illegal;
    logic             muldiv;
    logic [2:0]       mdop;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Maps an ALU-class funct3 to an operation; alt selects SUB/SRA
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  controlsgs_t w_ctrl;
  logic        w_illegal;
  logic        w_muldiv;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic        w_hazard;
  payload_t    w_dec;

  state_t      r_state;
  state_t      w_state_nxt;
  payload_t    r_main;
  payload_t    r_skid;
  logic        w_accept;
  logic        w_xfer;
  logic        w_load_main_in;
  logic        w_load_main_skid;
  logic        w_load_skid;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // Combinational decode of the incoming instruction word
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    w_ctrl     = '0;
    w_illegal  = 1'b0;
    w_muldiv   = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;

    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.alu_srca = SRCA_ZERO;
        w_ctrl.alu_srcb = SRCB_IMM;
        w_ctrl.immg_op  = IMMG_U;
        w_ctrl.reg_we   = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_srca = SRCA_PC;
        w_ctrl.alu_srcb = SRCB_IMM;
        w_ctrl.immg_op  = IMMG_U;
        w_ctrl.reg_we   = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.alu_srca    = SRCA_PC;
        w_ctrl.alu_srcb    = SRCB_IMM;
        w_ctrl.immg_op     = IMMG_J;
        w_ctrl.dataout_src = DOUT_PC4;
        w_ctrl.reg_we      = 1'b1;
        w_ctrl.bj_op       = BJ_JAL;
      end
      OPC_JALR: begin
        w_rs1_used         = 1'b1;
        w_ctrl.alu_srca    = SRCA_RS1;
        w_ctrl.alu_srcb    = SRCB_IMM;
        w_ctrl.immg_op     = IMMG_I;
        w_ctrl.dataout_src = DOUT_PC4;
        w_ctrl.reg_we      = 1'b1;
        w_ctrl.bj_op       = BJ_JALR;
      end
      OPC_BRANCH: begin
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        w_ctrl.alu_op   = ALU_SUB;
        w_ctrl.alu_srca = SRCA_RS1;
        w_ctrl.alu_srcb = SRCB_RS2;
        w_ctrl.immg_op  = IMMG_B;
        case (w_funct3)
          3'b000:  w_ctrl.bj_op = BJ_BEQ;
          3'b001:  w_ctrl.bj_op = BJ_BNE;
          3'b100:  w_ctrl.bj_op = BJ_BLT;
          3'b101:  w_ctrl.bj_op = BJ_BGE;
          3'b110:  w_ctrl.bj_op = BJ_BLTU;
          3'b111:  w_ctrl.bj_op = BJ_BGEU;
          default: w_illegal    = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_rs1_used         = 1'b1;
        w_ctrl.alu_srca    = SRCA_RS1;
        w_ctrl.alu_srcb    = SRCB_IMM;
        w_ctrl.immg_op     = IMMG_I;
        w_ctrl.dataout_src = DOUT_MEM;
        w_ctrl.reg_we      = 1'b1;
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        w_ctrl.alu_srca = SRCA_RS1;
        w_ctrl.alu_srcb = SRCB_IMM;
        w_ctrl.immg_op  = IMMG_S;
        w_ctrl.mem_d_we = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.mem_d_wdsrc = WD_BYTE;
          3'b001:  w_ctrl.mem_d_wdsrc = WD_HALF;
          3'b010:  w_ctrl.mem_d_wdsrc = WD_WORD;
          default: w_illegal          = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_rs1_used      = 1'b1;
        w_ctrl.alu_srca = SRCA_RS1;
        w_ctrl.alu_srcb = SRCB_IMM;
        w_ctrl.immg_op  = IMMG_I;
        w_ctrl.reg_we   = 1'b1;
        w_ctrl.alu_op   = f3_to_alu(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        // Shift-immediates carry a funct7 that must be a valid shift kind
        if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000)
          w_illegal = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)
          w_illegal = 1'b1;
      end
      OPC_OP: begin
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
        w_ctrl.alu_srca = SRCA_RS1;
        w_ctrl.alu_srcb = SRCB_RS2;
        w_ctrl.reg_we   = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_ctrl.alu_op = f3_to_alu(w_funct3, 1'b0);
        end else if (w_funct7 == 7'b0100000 &&
                     (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_ctrl.alu_op = f3_to_alu(w_funct3, 1'b1);
        end else if (ENABLE_M && w_funct7 == 7'b0000001) begin
          // The M unit ignores alu_op; ADD keeps the bundle deterministic
          w_muldiv      = 1'b1;
          w_ctrl.alu_op = ALU_ADD;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase

    // An illegal instruction must not write anything or redirect control flow
    if (w_illegal) begin
      w_ctrl   = '0;
      w_muldiv = 1'b0;
    end
  end

  // Load-use hazard: only register fields the instruction really reads count
  assign w_hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((w_rs1_used && (in_instr[19:15] == ex_load_rd)) ||
                     (w_rs2_used && (in_instr[24:20] == ex_load_rd)));

  // Assemble the payload that will be captured on acceptance
  always_comb begin
    w_dec         = '0;
    w_dec.ctrl    = w_ctrl;
    w_dec.pc      = in_pc;
    w_dec.instr   = in_instr;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.rd      = in_instr[11:7];
    w_dec.illegal = w_illegal;
    w_dec.muldiv  = w_muldiv;
    w_dec.mdop    = w_muldiv ? w_funct3 : 3'b000;
  end

  // Ready depends only on registered state and the hazard, never on out_ready
  assign in_ready  = (r_state != ST_SKID) && !w_hazard;
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_xfer    = out_valid && out_ready;

  // Skid-buffer next state and register load enables
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ST_MAIN;
            w_load_main_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (w_accept && w_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_SKID;
            w_load_skid = 1'b1;
          end else if (w_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_xfer) begin
            w_state_nxt      = ST_MAIN;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples values from before the clock edge.
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Main register: feeds the outputs, so it is cleared to the bubble encoding
  always_ff @(posedge clk) begin
    if (rst)                   r_main <= '0;
    else if (w_load_main_in)   r_main <= w_dec;
    else if (w_load_main_skid) r_main <= r_skid;
  end

  // Skid register: captures the entry accepted while main is stalled
  always_ff @(posedge clk) begin
    // NOTE: no reset here; the skid contents are only read when the state
    // says they are valid, so clearing them would buy nothing.
    if (w_load_skid) r_skid <= w_dec;
  end

  assign out_controlsgs = r_main.ctrl;
  assign out_pc         = r_main.pc;
  assign out_instr      = r_main.instr;
  assign out_rs1        = r_main.rs1;
  assign out_rs2        = r_main.rs2;
  assign out_rd         = r_main.rd;
  assign out_illegal    = r_main.illegal;
  assign out_muldiv     = r_main.muldiv;
  assign out_mdop       = r_main.mdop;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode table, RV32M on/off, back-pressure,
// load-use stalls, flush and mid-stream reset.

module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal, out_muldiv;
  controlsgs_t out_controlsgs;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_mdop;

  logic        nom_in_ready, nom_out_valid, nom_illegal, nom_muldiv;
  controlsgs_t nom_ctrl;
  logic [31:0] nom_pc, nom_instr;
  logic [4:0]  nom_rs1, nom_rs2, nom_rd;
  logic [2:0]  nom_mdop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_controlsgs(out_controlsgs),
    .out_pc(out_pc), .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_illegal(out_illegal), .out_muldiv(out_muldiv),
    .out_mdop(out_mdop)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u_dut_nom (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nom_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(nom_out_valid), .out_ready(out_ready), .out_controlsgs(nom_ctrl),
    .out_pc(nom_pc), .out_instr(nom_instr), .out_rs1(nom_rs1), .out_rs2(nom_rs2),
    .out_rd(nom_rd), .out_illegal(nom_illegal), .out_muldiv(nom_muldiv),
    .out_mdop(nom_mdop)
  );

  // Advance to just after the next rising edge (sample/drive point)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_rd(input int k);
    logic [11:0] imm = 12'(k);
    logic [4:0]  rd  = 5'(k);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  function automatic controlsgs_t mk(input alu_op_t a, input alu_srca_t sa,
                                     input alu_srcb_t sb, input mem_wdsrc_t wd,
                                     input logic mwe, input dataout_src_t ds,
                                     input logic rwe, input immg_op_t im,
                                     input bj_op_t bj);
    controlsgs_t c;
    c.alu_op = a; c.alu_srca = sa; c.alu_srcb = sb; c.mem_d_wdsrc = wd;
    c.mem_d_we = mwe; c.dataout_src = ds; c.reg_we = rwe; c.immg_op = im;
    c.bj_op = bj;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    ex_load_valid = 1'b0; ex_load_rd = 5'd0; out_ready = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_controlsgs !== controlsgs_t'('0)) begin bad++; $display("FAIL reset_ctrl got=%h want=0", out_controlsgs); end
    total++; if (out_controlsgs.bj_op !== BJ_NOOP) begin bad++; $display("FAIL reset_bj_op got=%0d want=NOOP", out_controlsgs.bj_op); end
    total++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_rd !== 5'd0) begin bad++; $display("FAIL reset_payload pc=%h instr=%h rd=%0d want zeros", out_pc, out_instr, out_rd); end
    total++; if (out_illegal !== 1'b0 || out_muldiv !== 1'b0) begin bad++; $display("FAIL reset_flags illegal=%b muldiv=%b want 0/0", out_illegal, out_muldiv); end
    rst = 1'b0;
  endtask

  task automatic test_basic_decode();
    out_ready = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_controlsgs !== mk(ALU_ADD, SRCA_RS1, SRCB_IMM, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_I, BJ_NOOP)) begin bad++; $display("FAIL basic_ctrl got=%h", out_controlsgs); end
    total++; if (out_rd !== 5'd1 || out_illegal !== 1'b0) begin bad++; $display("FAIL basic_rd_illegal rd=%0d illegal=%b want 1/0", out_rd, out_illegal); end
    total++; if (out_pc !== 32'h100 || out_instr !== 32'h00500093) begin bad++; $display("FAIL basic_pc_instr pc=%h instr=%h want 100/00500093", out_pc, out_instr); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
  endtask

  // Streams a table of instructions one per cycle with out_ready held high
  task automatic test_decode_table();
    logic [31:0] ins [13];
    controlsgs_t exp [13];
    logic        ill [13];
    controlsgs_t z = '0;
    ins[0]  = 32'h0020A223; exp[0]  = mk(ALU_ADD, SRCA_RS1, SRCB_IMM, WD_WORD, 1'b1, DOUT_ALUY, 1'b0, IMMG_S, BJ_NOOP); ill[0] = 1'b0; // sw
    ins[1]  = 32'h00208463; exp[1]  = mk(ALU_SUB, SRCA_RS1, SRCB_RS2, WD_BYTE, 1'b0, DOUT_ALUY, 1'b0, IMMG_B, BJ_BEQ);  ill[1] = 1'b0; // beq
    ins[2]  = 32'h0020A463; exp[2]  = z; ill[2] = 1'b1; // branch funct3 010
    ins[3]  = 32'h4020D093; exp[3]  = mk(ALU_SRA, SRCA_RS1, SRCB_IMM, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_I, BJ_NOOP); ill[3] = 1'b0; // srai
    ins[4]  = 32'h40209093; exp[4]  = z; ill[4] = 1'b1; // slli with funct7 0100000
    ins[5]  = 32'h402081B3; exp[5]  = mk(ALU_SUB, SRCA_RS1, SRCB_RS2, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_NONE, BJ_NOOP); ill[5] = 1'b0; // sub
    ins[6]  = 32'h4020E1B3; exp[6]  = z; ill[6] = 1'b1; // or with funct7 0100000
    ins[7]  = 32'h0040A183; exp[7]  = mk(ALU_ADD, SRCA_RS1, SRCB_IMM, WD_BYTE, 1'b0, DOUT_MEM, 1'b1, IMMG_I, BJ_NOOP); ill[7] = 1'b0; // lw
    ins[8]  = 32'h0040B183; exp[8]  = z; ill[8] = 1'b1; // load funct3 011
    ins[9]  = 32'h0020B223; exp[9]  = z; ill[9] = 1'b1; // store funct3 011
    ins[10] = 32'h123450B7; exp[10] = mk(ALU_ADD, SRCA_ZERO, SRCB_IMM, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_U, BJ_NOOP); ill[10] = 1'b0; // lui
    ins[11] = 32'h000000EF; exp[11] = mk(ALU_ADD, SRCA_PC, SRCB_IMM, WD_BYTE, 1'b0, DOUT_PC4, 1'b1, IMMG_J, BJ_JAL); ill[11] = 1'b0; // jal
    ins[12] = 32'h0000007F; exp[12] = z; ill[12] = 1'b1; // unknown opcode
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_instr = ins[i]; in_pc = 32'h400 + 32'(i * 4); in_valid = 1'b1;
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== ins[i]) begin bad++; $display("FAIL table%0d_valid valid=%b instr=%h want 1/%h", i, out_valid, out_instr, ins[i]); end
      total++; if (out_controlsgs !== exp[i]) begin bad++; $display("FAIL table%0d_ctrl got=%h want=%h", i, out_controlsgs, exp[i]); end
      total++; if (out_illegal !== ill[i] || out_muldiv !== 1'b0) begin bad++; $display("FAIL table%0d_flags illegal=%b muldiv=%b want %b/0", i, out_illegal, out_muldiv, ill[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1; in_instr = 32'h02208033; in_pc = 32'h500; in_valid = 1'b1; // mul x0,x1,x2
    step();
    in_instr = 32'h0220C033; // div x0,x1,x2
    total++; if (out_valid !== 1'b1 || out_muldiv !== 1'b1 || out_mdop !== 3'b000 || out_illegal !== 1'b0) begin bad++; $display("FAIL mul_flags valid=%b muldiv=%b mdop=%b illegal=%b", out_valid, out_muldiv, out_mdop, out_illegal); end
    total++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd0) begin bad++; $display("FAIL mul_regs rs1=%0d rs2=%0d rd=%0d want 1/2/0", out_rs1, out_rs2, out_rd); end
    total++; if (out_controlsgs !== mk(ALU_ADD, SRCA_RS1, SRCB_RS2, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_NONE, BJ_NOOP)) begin bad++; $display("FAIL mul_ctrl got=%h", out_controlsgs); end
    total++; if (nom_out_valid !== 1'b1 || nom_illegal !== 1'b1 || nom_ctrl !== controlsgs_t'('0) || nom_muldiv !== 1'b0 || nom_mdop !== 3'b000) begin bad++; $display("FAIL nom_mul valid=%b illegal=%b ctrl=%h muldiv=%b mdop=%b", nom_out_valid, nom_illegal, nom_ctrl, nom_muldiv, nom_mdop); end
    total++; if (nom_pc !== 32'h500 || nom_instr !== 32'h02208033 || nom_rs1 !== 5'd1 || nom_rs2 !== 5'd2 || nom_rd !== 5'd0 || nom_in_ready !== 1'b1) begin bad++; $display("FAIL nom_raw pc=%h instr=%h rs=%0d,%0d rd=%0d rdy=%b", nom_pc, nom_instr, nom_rs1, nom_rs2, nom_rd, nom_in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_muldiv !== 1'b1 || out_mdop !== 3'b100 || out_controlsgs.reg_we !== 1'b1) begin bad++; $display("FAIL div_flags muldiv=%b mdop=%b reg_we=%b want 1/100/1", out_muldiv, out_mdop, out_controlsgs.reg_we); end
    step();
  endtask

  task automatic test_back_to_back();
    int   idx = 1;
    int   outk = 1;
    logic took;
    logic exp_rdy [3];
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_instr = addi_rd(idx); in_pc = 32'h1000 + 32'(idx * 4); in_valid = 1'b1;
      #1;
      total++; if (in_ready !== exp_rdy[c]) begin bad++; $display("FAIL b2b_ready%0d got=%b want=%b", c, in_ready, exp_rdy[c]); end
      took = in_ready;
      step();
      if (took) idx++;
      total++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin bad++; $display("FAIL b2b_hold%0d valid=%b rd=%0d want 1/1", c, out_valid, out_rd); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++; if (out_valid !== 1'b1 || out_rd !== 5'(outk) || out_pc !== 32'h1000 + 32'(outk * 4)) begin bad++; $display("FAIL b2b_out%0d valid=%b rd=%0d pc=%h want rd=%0d", c, out_valid, out_rd, out_pc, outk); end
      outk++;
      if (idx <= 4) begin
        in_instr = addi_rd(idx); in_pc = 32'h1000 + 32'(idx * 4); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      took = in_valid && in_ready;
      step();
      if (took) idx++;
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || idx !== 5) begin bad++; $display("FAIL b2b_end valid=%b accepted=%0d want 0/4", out_valid, idx - 1); end
  endtask

  task automatic test_load_use();
    out_ready = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd1;
    in_instr = 32'h002081B3; in_pc = 32'h600; in_valid = 1'b1; // add x3,x1,x2
    #1;
    for (int c = 0; c < 3; c++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hazard_ready%0d got=%b want=0", c, in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_nodeliver%0d got=%b want=0", c, out_valid); end
    end
    ex_load_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin bad++; $display("FAIL hazard_deliver valid=%b rd=%0d want 1/3", out_valid, out_rd); end
    step();
    ex_load_valid = 1'b1;
    ex_load_rd = 5'd0; in_instr = 32'h002001B3; #1; // add x3,x0,x2: rd=0 never stalls
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_rd0 got=%b want=1", in_ready); end
    ex_load_rd = 5'd8; in_instr = 32'h123450B7; #1; // lui: rs1 field 8 unused
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_lui got=%b want=1", in_ready); end
    ex_load_rd = 5'd2; in_instr = 32'h0020A223; #1; // sw reads rs2=x2
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hazard_store_rs2 got=%b want=0", in_ready); end
    ex_load_rd = 5'd5; in_instr = 32'h00500093; #1; // addi: rs2 field 5 unused
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_addi_rs2 got=%b want=1", in_ready); end
    ex_load_valid = 1'b0; ex_load_rd = 5'd0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_instr = addi_rd(1); in_valid = 1'b1; step();
    in_instr = addi_rd(2); step();
    total++; if (in_ready !== 1'b0 || out_rd !== 5'd1) begin bad++; $display("FAIL flush_skidfull ready=%b rd=%0d want 0/1", in_ready, out_rd); end
    flush = 1'b1; in_instr = addi_rd(7);
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear valid=%b ready=%b want 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d valid=%b rd=%0d want 0", c, out_valid, out_rd); end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_instr = addi_rd(1); in_pc = 32'h700; in_valid = 1'b1; step();
    in_instr = addi_rd(2); step();
    rst = 1'b1; in_instr = addi_rd(9);
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_hs valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if (out_controlsgs !== controlsgs_t'('0) || out_pc !== 32'h0 || out_rd !== 5'd0 || out_instr !== 32'h0 || out_illegal !== 1'b0 || out_muldiv !== 1'b0) begin bad++; $display("FAIL rstmid_payload ctrl=%h pc=%h rd=%0d instr=%h", out_controlsgs, out_pc, out_rd, out_instr); end
    out_ready = 1'b1; in_instr = addi_rd(5); in_pc = 32'h200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_pc !== 32'h200) begin bad++; $display("FAIL rstmid_next valid=%b rd=%0d pc=%h want 1/5/200", out_valid, out_rd, out_pc); end
    total++; if (out_controlsgs !== mk(ALU_ADD, SRCA_RS1, SRCB_IMM, WD_BYTE, 1'b0, DOUT_ALUY, 1'b1, IMMG_I, BJ_NOOP)) begin bad++; $display("FAIL rstmid_ctrl got=%h", out_controlsgs); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_decode_table();
    test_muldiv();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
